// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the multiplier arbiter slice.
//   - Q8.7 fixed-point data format constants
//   - Default watchdog limit
//   - Arbiter state encoding (3-bit)
// ---------------------------------------------------------------------------
package mul_pkg;

  localparam int DATA_W      = 16;
  localparam int Q_FRAC      = 7;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_LOAD = 3'd2,
    WAIT_DONE = 3'd3,
    RESPOND   = 3'd4
  } state_t;

endpackage

// File: rtl/mul_arbiter_if.sv
// ---------------------------------------------------------------------------
// mul_arbiter_if
// Bundles the requester-side and multiplier-side signals of mul_arbiter.
//   Requester side : req, op_a, op_b (in)  / gnt, busy, rsp_* (out)
//   Multiplier side: mul_finish, mul_result, mul_overflow (in)
//                    / mul_start, mul_a, mul_b (out)
// Modports:
//   slave  - the arbiter view
//   master - the environment view (requesters + multiplier)
// ---------------------------------------------------------------------------
interface mul_arbiter_if
  import mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);

  logic [NUM_REQ-1:0]        req;
  logic [DATA_W*NUM_REQ-1:0] op_a;
  logic [DATA_W*NUM_REQ-1:0] op_b;
  logic [NUM_REQ-1:0]        gnt;
  logic                      busy;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_result;
  logic                      rsp_overflow;
  logic                      rsp_timeout;
  logic                      mul_start;
  logic [DATA_W-1:0]         mul_a;
  logic [DATA_W-1:0]         mul_b;
  logic                      mul_finish;
  logic [DATA_W-1:0]         mul_result;
  logic                      mul_overflow;

  modport slave (
    input  req, op_a, op_b, mul_finish, mul_result, mul_overflow,
    output gnt, busy, rsp_valid, rsp_id, rsp_result, rsp_overflow,
           rsp_timeout, mul_start, mul_a, mul_b
  );

  modport master (
    output req, op_a, op_b, mul_finish, mul_result, mul_overflow,
    input  gnt, busy, rsp_valid, rsp_id, rsp_result, rsp_overflow,
           rsp_timeout, mul_start, mul_a, mul_b
  );

endinterface

// File: rtl/mul_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin priority select.
//   i_req : request vector
//   i_ptr : index with highest priority this round
//   o_gnt : one-hot grant (first set bit searching upward from i_ptr, wrapping)
//   o_idx : index of the granted bit
//   o_any : at least one request present
// ---------------------------------------------------------------------------
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic [ID_W-1:0] w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = ID_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_idx      = w_j;
        o_gnt[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// ---------------------------------------------------------------------------
// mul_arbiter
// Round-robin arbiter/sequencer sharing one Q8.7 Booth multiplier among
// NUM_REQ requesters. One operation is outstanding at a time.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - mul_arbiter_if.slave (requester handshake, response, multiplier)
// Every output is a register. An action taken in a state becomes visible in
// the following cycle: gnt shows during ISSUE, mul_start during WAIT_LOAD,
// rsp_valid during the IDLE cycle after RESPOND. busy tracks the state.
// ---------------------------------------------------------------------------
module mul_arbiter
  import mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic          clk,
  input logic          rst,
  mul_arbiter_if.slave bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t              r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_cur_id;
  logic [WD_W-1:0]     r_wd;
  logic [NUM_REQ-1:0]  r_gnt;
  logic                r_busy;
  logic                r_rsp_valid;
  logic [ID_W-1:0]     r_rsp_id;
  logic [DATA_W-1:0]   r_rsp_result;
  logic                r_rsp_overflow;
  logic                r_rsp_timeout;
  logic                r_mul_start;
  logic [DATA_W-1:0]   r_mul_a;
  logic [DATA_W-1:0]   r_mul_b;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]     w_idx;
  logic                w_any;
  logic [DATA_W-1:0]   w_op_a [NUM_REQ];
  logic [DATA_W-1:0]   w_op_b [NUM_REQ];

  // Unpack the flat operand buses so the granted slice can be indexed directly.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_op_a[g] = bus.op_a[g*DATA_W +: DATA_W];
    assign w_op_b[g] = bus.op_b[g*DATA_W +: DATA_W];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_ptr          <= '0;
      r_cur_id       <= '0;
      r_wd           <= '0;
      r_gnt          <= '0;
      r_busy         <= 1'b0;
      r_rsp_valid    <= 1'b0;
      r_rsp_id       <= '0;
      r_rsp_result   <= '0;
      r_rsp_overflow <= 1'b0;
      r_rsp_timeout  <= 1'b0;
      r_mul_start    <= 1'b0;
      r_mul_a        <= '0;
      r_mul_b        <= '0;
    end else begin
      // Single-cycle strobes default low.
      r_gnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_mul_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt    <= w_gnt;
            r_mul_a  <= w_op_a[w_idx];
            r_mul_b  <= w_op_b[w_idx];
            r_cur_id <= w_idx;
            // Winner moves to lowest priority for the next round.
            r_ptr    <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
            r_busy   <= 1'b1;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          r_mul_start <= 1'b1;
          r_state     <= WAIT_LOAD;
        end
        WAIT_LOAD: begin
          // mul_finish may still carry the previous result here; ignore it.
          r_wd    <= '0;
          r_state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.mul_finish) begin
            r_rsp_result   <= bus.mul_result;
            r_rsp_overflow <= bus.mul_overflow;
            r_rsp_timeout  <= 1'b0;
            r_state        <= RESPOND;
          end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th cycle without finish: abort.
            r_rsp_result   <= '0;
            r_rsp_overflow <= 1'b0;
            r_rsp_timeout  <= 1'b1;
            r_state        <= RESPOND;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        RESPOND: begin
          r_rsp_valid <= 1'b1;
          r_rsp_id    <= r_cur_id;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt          = r_gnt;
  assign bus.busy         = r_busy;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_id       = r_rsp_id;
  assign bus.rsp_result   = r_rsp_result;
  assign bus.rsp_overflow = r_rsp_overflow;
  assign bus.rsp_timeout  = r_rsp_timeout;
  assign bus.mul_start    = r_mul_start;
  assign bus.mul_a        = r_mul_a;
  assign bus.mul_b        = r_mul_b;

endmodule

// File: tb/tb_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mul_arbiter
// Scoreboard bench for mul_arbiter with a behavioural Booth-multiplier model.
// A monitor predicts each grant from the request vector and its own
// round-robin pointer, queues the expected response, and checks every
// rsp_valid strobe against the queue head.
// ---------------------------------------------------------------------------
module tb_mul_arbiter;
  import mul_pkg::*;

  localparam int NR      = 4;
  localparam int IW      = 2;
  localparam int TO      = 15;
  localparam int MUL_LAT = 8;            // multiplier working cycles after load
  localparam int NOM_WD  = MUL_LAT + 1;  // WAIT_DONE cycles until finish is seen

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_arbiter_if #(.NUM_REQ(NR), .ID_W(IW)) bus ();

  mul_arbiter #(.NUM_REQ(NR), .ID_W(IW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Q8.7 product with overflow: {overflow, result}.
  function automatic logic [16:0] qmul(input logic [15:0] a, input logic [15:0] b);
    longint p;
    longint q;
    p = longint'($signed(a)) * longint'($signed(b));
    q = p >>> 7;
    qmul = {(q > 32767 || q < -32768), q[15:0]};
  endfunction

  // ---------------- multiplier model (not reset by the arbiter reset) -------
  logic        m_start_d = 1'b0;
  logic        m_finish  = 1'b0;
  logic [15:0] m_result  = '0;
  logic        m_ovf     = 1'b0;
  int          m_cnt     = 0;
  logic [16:0] m_prod    = '0;
  bit          m_stall   = 1'b0;

  assign bus.mul_finish   = m_finish;
  assign bus.mul_result   = m_result;
  assign bus.mul_overflow = m_ovf;

  always @(posedge clk) begin
    m_start_d <= bus.mul_start;
    if (bus.mul_start && !m_start_d) begin
      m_finish <= 1'b0;
      m_cnt    <= MUL_LAT;
      m_prod   <= qmul(bus.mul_a, bus.mul_b);
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && !m_stall) begin
        m_finish <= 1'b1;
        m_result <= m_prod[15:0];
        m_ovf    <= m_prod[16];
      end
    end
  end

  // ---------------- input sampling and scoreboard ---------------------------
  typedef struct {
    int          id;
    logic [15:0] res;
    logic        ovf;
    logic        to;
    int          gcyc;
    int          lat;
  } exp_t;

  exp_t               sb[$];
  int                 glog[$];
  int                 rr_ptr   = 0;
  int                 cyc      = 0;
  int                 n_start  = 0;
  int                 idle_cnt = 0;
  int                 rr_prev  = -1;
  bit                 rr_phase = 1'b0;
  logic [NR-1:0]      req_s    = '0;
  logic [16*NR-1:0]   opa_s    = '0;
  logic [16*NR-1:0]   opb_s    = '0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    req_s <= bus.req;
    opa_s <= bus.op_a;
    opb_s <= bus.op_b;
  end

  always @(negedge clk) begin
    if (bus.mul_start) n_start++;
    if (!bus.busy) idle_cnt++;
    if (rst && bus.gnt != '0) begin
      int   pick;
      exp_t e;
      logic [16:0] p;
      pick = -1;
      for (int k = 0; k < NR; k++)
        if (pick < 0 && req_s[(rr_ptr + k) % NR]) pick = (rr_ptr + k) % NR;
      check("gnt_onehot", 32'($countones(bus.gnt)), 32'd1);
      check("gnt_index", 32'(bus.gnt), (pick >= 0) ? (32'd1 << pick) : 32'd0);
      if (pick >= 0) begin
        p      = qmul(opa_s[pick*16 +: 16], opb_s[pick*16 +: 16]);
        e.id   = pick;
        e.res  = m_stall ? 16'h0 : p[15:0];
        e.ovf  = m_stall ? 1'b0 : p[16];
        e.to   = m_stall;
        e.gcyc = cyc;
        e.lat  = 3 + (m_stall ? TO : NOM_WD);
        sb.push_back(e);
        glog.push_back(pick);
        rr_ptr = (pick + 1) % NR;
      end
      if (rr_phase) begin
        if (rr_prev >= 0) begin
          check("rr_gap", 32'(cyc - rr_prev), 32'd13);
          check("rr_busy_low", 32'(idle_cnt), 32'd1);
        end
        rr_prev = cyc;
      end
      idle_cnt = 0;
      n_start  = 0;
    end
    if (rst && bus.rsp_valid) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        check("rsp_result", 32'(bus.rsp_result), 32'(e.res));
        check("rsp_overflow", 32'(bus.rsp_overflow), 32'(e.ovf));
        check("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.to));
        check("rsp_latency", 32'(cyc - e.gcyc), 32'(e.lat));
        check("start_pulses", 32'(n_start), 32'd1);
      end
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic wait_gnt(input int i, input int maxc);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < maxc && !seen; c++) begin
      @(negedge clk);
      if (bus.gnt[i]) seen = 1'b1;
    end
    if (!seen) check("wait_gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int maxc);
    bit done;
    done = 1'b0;
    for (int c = 0; c < maxc && !done; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.busy) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input int i, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.op_a[i*16 +: 16] = a;
    bus.op_b[i*16 +: 16] = b;
    bus.req[i] = 1'b1;
    wait_gnt(i, 40);
    check("busy_in_op", 32'(bus.busy), 32'd1);
    bus.req[i] = 1'b0;
    drain(40);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    sb.delete();
    rr_ptr = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_mul_start"}, 32'(bus.mul_start), 32'd0);
    check({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
    check({tag, "_rsp_result"}, 32'(bus.rsp_result), 32'd0);
    check({tag, "_rsp_overflow"}, 32'(bus.rsp_overflow), 32'd0);
    check({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout), 32'd0);
    check({tag, "_mul_a"}, 32'(bus.mul_a), 32'd0);
    check({tag, "_mul_b"}, 32'(bus.mul_b), 32'd0);
  endtask

  function automatic logic [15:0] rnd_op();
    logic [15:0] tbl [5];
    tbl[0] = 16'h7FFF; tbl[1] = 16'h8000; tbl[2] = 16'h0000;
    tbl[3] = 16'h0080; tbl[4] = 16'hFF80;
    if ($urandom_range(0, 3) == 0) rnd_op = tbl[$urandom_range(0, 4)];
    else rnd_op = 16'($urandom);
  endfunction

  // ---------------- main sequence --------------------------------------------
  initial begin
    rst      = 1'b0;
    bus.req  = '0;
    bus.op_a = '0;
    bus.op_b = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    // Directed operations.
    do_op(1, 16'h0100, 16'h0180);   // 2.0 * 3.0 = 6.0
    do_op(3, 16'hFF40, 16'h0100);   // -1.5 * 2.0 = -3.0
    do_op(0, 16'h4000, 16'h4000);   // 128 * 128 overflows

    // All requesters held from reset: strict rotation, one op per 13 cycles.
    pulse_reset();
    glog.delete();
    rr_prev  = -1;
    rr_phase = 1'b1;
    for (int i = 0; i < NR; i++) begin
      bus.op_a[i*16 +: 16] = rnd_op();
      bus.op_b[i*16 +: 16] = rnd_op();
    end
    bus.req = '1;
    for (int c = 0; c < 100 && glog.size() < 5; c++) @(negedge clk);
    bus.req  = '0;
    rr_phase = 1'b0;
    check("rr_count", 32'(glog.size()), 32'd5);
    for (int k = 0; k < 5 && k < glog.size(); k++)
      check("rr_order", 32'(glog[k]), 32'(k % NR));
    drain(60);

    // Watchdog, then a normal operation.
    m_stall = 1'b1;
    do_op(2, 16'h0100, 16'h0100);
    m_stall = 1'b0;
    do_op(2, 16'h0080, 16'h0100);

    // Reset during WAIT_DONE discards the in-flight operation.
    @(negedge clk);
    bus.op_a[16 +: 16] = 16'h0200;
    bus.op_b[16 +: 16] = 16'h0200;
    bus.req[1] = 1'b1;
    wait_gnt(1, 40);
    bus.req[1] = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midreset");
    sb.delete();
    rr_ptr = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    do_op(2, 16'h0080, 16'h0080);   // 1.0 * 1.0 = 1.0

    // Randomized traffic.
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (bus.gnt[i]) begin
          bus.op_a[i*16 +: 16] = rnd_op();
          bus.op_b[i*16 +: 16] = rnd_op();
          if ($urandom_range(0, 1) == 0) bus.req[i] = 1'b0;
        end else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
          bus.op_a[i*16 +: 16] = rnd_op();
          bus.op_b[i*16 +: 16] = rnd_op();
          bus.req[i] = 1'b1;
        end
      end
    end
    @(negedge clk);
    bus.req = '0;
    drain(80);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one 16-bit fixed-point modified-Booth multiplier (multiplier_modified_booth) among NUM_REQ ODE datapath requesters.
- Fixed-point format is Q8.7: 16-bit two's complement, 7 fraction bits.
- Grants one requester and latches its operands. Drives the multiplier's edge-sensitive start, then waits for finish and returns the result, overflow flag and requester ID.
- A watchdog bounds each operation.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must satisfy 2^ID_W >= NUM_REQ.
- TIMEOUT, 15, maximum cycles spent in WAIT_DONE before the operation is aborted.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request, level; held until the matching gnt.
- op_a  in  16*NUM_REQ  packed multiplicands; slice i = [16i+15:16i].
- op_b  in  16*NUM_REQ  packed multipliers; same slicing.
- gnt  out  NUM_REQ  one-hot, one-cycle accept pulse.
- busy  out  1  high whenever state != IDLE.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  ID_W  requester index of the response.
- rsp_result  out  16  product (Q8.7).
- rsp_overflow  out  1  multiplier overflow flag, sampled with finish.
- rsp_timeout  out  1  operation aborted by the watchdog.
- mul_start  out  1  to multiplier start.
- mul_a  out  16  to multiplier multiplicand.
- mul_b  out  16  to multiplier multiplier.
- mul_finish  in  1  from multiplier finish.
- mul_result  in  16  from multiplier result.
- mul_overflow  in  1  from multiplier overflow_flag.

Behaviour:
- Reset (rst=0, async): state=IDLE, rr pointer=0. gnt, rsp_valid, mul_start and busy are 0. rsp_id, rsp_result, rsp_overflow, rsp_timeout, mul_a and mul_b are 0.
- All outputs are registered.
- States: IDLE -> ISSUE -> WAIT_LOAD -> WAIT_DONE -> RESPOND -> IDLE.
- IDLE:
  - If req != 0, pick the first set bit searching upward from the rr pointer, with wrap-around.
  - Pulse gnt[i] for 1 cycle, latch op_a/op_b slice i into mul_a/mul_b and latch i as cur_id.
  - Set rr pointer = (i+1) mod NUM_REQ, then go to ISSUE.
  - With req == 0, stay in IDLE and leave the pointer unchanged.
- ISSUE: mul_start=1 for exactly this cycle (rising edge arms the multiplier) -> WAIT_LOAD.
- WAIT_LOAD:
  - One cycle, mul_start=0.
  - In this cycle the multiplier loads its operands and clears its stale finish, so mul_finish is ignored here.
  - Clear the watchdog counter -> WAIT_DONE.
- WAIT_DONE:
  - On mul_finish=1, capture mul_result and mul_overflow, set rsp_timeout=0 -> RESPOND.
  - Otherwise increment the watchdog. When it reaches TIMEOUT, set rsp_result=0, rsp_overflow=0, rsp_timeout=1 -> RESPOND.
  - Nominal multiplier latency is 8 cycles in WAIT_DONE.
- RESPOND: rsp_valid=1 for 1 cycle with rsp_id=cur_id -> IDLE.
- Total from grant to rsp_valid is 12 cycles nominal. At most one operation is outstanding; new requests are not sampled until IDLE.
- mul_a and mul_b are held stable from ISSUE through RESPOND.
- A requester may drop req the cycle after gnt. A request still asserted after its response is treated as a new request.
- Simultaneous requests: resolved strictly by the rr pointer. A continuously requesting set is served i, i+1, ... in rotation.
- Requester i keeping req high while its response returns is not re-granted before lower-priority waiting requesters.
- Reset mid-operation: the arbiter returns to IDLE immediately and the in-flight result is discarded. The next ISSUE restarts the multiplier, because a pending start has priority over working in the multiplier.
- rsp_* registers hold their last values between strobes. Only rsp_valid qualifies them.

Decomposition:
- Shared package mul_pkg holds:
  - State encoding constants: IDLE=0, ISSUE=1, WAIT_LOAD=2, WAIT_DONE=3, RESPOND=4 (3-bit).
  - Q_FRAC=7, DATA_W=16, default TIMEOUT.
- One natural sub-module: rr_picker, a combinational round-robin priority select. It takes req and the pointer and returns the one-hot grant and the index.

Test Plan:
- Single request: req[1], op_a=0x0100 (2.0), op_b=0x0180 (3.0) -> gnt[1] pulse, one mul_start pulse. rsp_valid 12 cycles after gnt with rsp_id=1, rsp_result=0x0300, rsp_overflow=0, rsp_timeout=0.
- Signed operands: op_a=0xFF40 (-1.5), op_b=0x0100 (2.0) on req[3] -> rsp_result=0xFE80, rsp_id=3.
- Overflow: op_a=0x4000, op_b=0x4000 -> rsp_overflow=1, rsp_timeout=0.
- All four req held high from reset with pointer 0 -> grants in order 0,1,2,3,0, with exactly one operation per 13-cycle window and busy low for 1 cycle between operations.
- Watchdog: multiplier model holds mul_finish=0 -> rsp_valid after 15 WAIT_DONE cycles with rsp_timeout=1, rsp_result=0. The next request completes normally.
- Reset during WAIT_DONE: assert rst=0 for 2 cycles -> outputs go to reset values asynchronously with no rsp_valid. A post-reset request (0x0080 * 0x0080) returns 0x0080.
